// File: rtl/i2s_audio_tx.sv
// I2S serializer for the headphone/amplifier DAC, fed from a 2-entry stereo sample FIFO.
// The bit clock is a registered output of the pixel-clock domain; every slot update happens on its falling edge.
module i2s_audio_tx #(
    parameter logic STEREO           = 1'b1,
    parameter int   AUDIO_SHIFT      = 0,
    parameter logic PA_EN_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        pll_lock,
    input  logic        enable,
    input  logic [7:0]  bck_div,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din,
    output logic        pa_en,
    output logic        frame_start,
    output logic        underrun
);

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } smp_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    smp_t [1:0]       mem;
    smp_t             hold;
    logic             wr_ptr, rd_ptr;
    logic [1:0]       fifo_cnt, cnt_nxt;
    logic             wr_en, rd_en;
    logic [7:0]       div_cnt, div_lim;
    logic [4:0]       slot, slot_nxt;
    logic [31:0]      shreg;
    logic             pa_on;
    logic             div_wrap, fall, stop, boundary;
    logic [15:0]      mono;
    logic [1:0][15:0] pre, word;

    assign wr_en    = in_valid && in_ready;
    assign div_wrap = (div_cnt == div_lim);
    assign fall     = (state != IDLE) && div_wrap && hp_bck;
    assign slot_nxt = slot + 5'd1;
    assign stop     = fall && (slot == 5'd31) && (state == DRAIN) && !enable;
    // Starting a run counts as a frame boundary so the first frame has a popped sample.
    assign boundary = ((state == IDLE) && enable) || (fall && (slot == 5'd31) && !stop);
    assign rd_en    = boundary && (fifo_cnt != 2'd0);

    assign hp_din = shreg[31];
    assign pa_en  = pa_on ^ PA_EN_ACTIVE_LOW;

    always_comb begin
        cnt_nxt = fifo_cnt;
        if (wr_en && !rd_en)
            cnt_nxt = fifo_cnt + 2'd1;
        else if (rd_en && !wr_en)
            cnt_nxt = fifo_cnt - 2'd1;
    end

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            mem      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= '{l: in_l, r: in_r};
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= cnt_nxt;
            // Looks at the next count so a write can never land on a full FIFO.
            in_ready <= (cnt_nxt != 2'd2);
        end
    end

    // Mono mix: the 17-bit sum shifted by one always fits back into 16 bits.
    assign mono   = 16'(({hold.l[15], hold.l} + {hold.r[15], hold.r}) >> 1);
    assign pre[1] = STEREO ? hold.l : mono;
    assign pre[0] = STEREO ? hold.r : mono;

    for (genvar c = 0; c < 2; c++) begin : g_att
        assign word[c] = 16'($signed(pre[c]) >>> AUDIO_SHIFT);
    end

    always_ff @(posedge clk or negedge pll_lock) begin
        if (!pll_lock) begin
            state       <= IDLE;
            div_cnt     <= '0;
            div_lim     <= '0;
            slot        <= '0;
            hp_bck      <= 1'b0;
            hp_ws       <= 1'b0;
            shreg       <= '0;
            pa_on       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            hold        <= '0;
        end else begin
            frame_start <= boundary;
            underrun    <= boundary && !rd_en;
            if (rd_en)
                hold <= mem[rd_ptr];
            if (state == IDLE) begin
                div_cnt <= '0;
                slot    <= '0;
                hp_bck  <= 1'b0;
                hp_ws   <= 1'b0;
                shreg   <= '0;
                if (enable) begin
                    state   <= RUN;
                    pa_on   <= 1'b1;
                    div_lim <= bck_div;
                end
            end else begin
                if (enable)
                    state <= RUN;
                else if (state == RUN)
                    state <= DRAIN;
                if (div_wrap) begin
                    div_cnt <= '0;
                    div_lim <= bck_div;
                    hp_bck  <= ~hp_bck;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
                if (stop) begin
                    state <= IDLE;
                    pa_on <= 1'b0;
                    slot  <= '0;
                    hp_ws <= 1'b0;
                    shreg <= '0;
                end else if (fall) begin
                    slot  <= slot_nxt;
                    hp_ws <= slot_nxt[4];
                    // One-bit I2S delay: the word is loaded entering slot 1, then shifted.
                    shreg <= (slot == 5'd0) ? {word[1], word[0]} : {shreg[30:0], 1'b0};
                end
            end
        end
    end

endmodule
